// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the pipelined RV32I core. It serves DMEM-stage
//   load/store requests and registers load data one cycle later for WB.
//   Word and byte accesses are little-endian (lane 0 = bits [7:0]).
//   Misaligned word accesses raise a sticky flag. Accesses outside storage
//   read as zero and never write.
//
//   Optional feature, enabled by defining the macro DMEM_MMIO_EN:
//     MMIO_BASE+0x0  tohost: word write latches data and pulses tohost_valid;
//                    word read returns the latched value.
//     MMIO_BASE+0x4  free-running cycle counter (read-only).
//   Without the macro the window is plain out-of-range space and the tohost
//   outputs are tied to zero.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (storage is not cleared)
//   addr         byte address of the request
//   memRead      load request this cycle
//   memWrite     store request this cycle
//   memMode      0 = word access, 1 = byte access
//   dataIn       store data (byte mode uses dataIn[7:0])
//   dataOut      registered load data, valid the cycle after memRead
//   misaligned   sticky: some word access had addr[1:0] != 0
//   tohost_valid one-cycle pulse after a tohost write
//   tohost_data  last value written to tohost
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE   = 32'hFFFF_FF00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic                  memMode,
  input  logic [WORD_WIDTH-1:0] dataIn,
  output logic [WORD_WIDTH-1:0] dataOut,
  output logic                  misaligned,
  output logic                  tohost_valid,
  output logic [WORD_WIDTH-1:0] tohost_data
);

  localparam int                  IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES_C = (ADDR_WIDTH+1)'(DEPTH_WORDS * 32'sd4);

  logic [WORD_WIDTH-1:0] mem_r [DEPTH_WORDS];

  logic [IDX_W-1:0]      word_idx_s;
  logic [1:0]            lane_s;
  logic                  in_range_s;
  logic                  window_s;
  logic                  req_s;
  logic                  misalign_s;
  logic [WORD_WIDTH-1:0] rd_word_s;
  logic [7:0]            lane_byte_s;
  logic [WORD_WIDTH-1:0] merged_s;
  logic [WORD_WIDTH-1:0] rd_data_s;
  logic                  mem_we_s;
  logic [WORD_WIDTH-1:0] mem_wdata_s;

  assign word_idx_s = addr[2 +: IDX_W];
  assign lane_s     = addr[1:0];
  // Zero-extend so that addresses at or above the storage size never alias.
  assign in_range_s = ({1'b0, addr} < MEM_BYTES_C);
  // 8-byte MMIO window: bit 2 selects tohost (0) or the cycle counter (1).
  assign window_s   = (addr[ADDR_WIDTH-1:3] == MMIO_BASE[ADDR_WIDTH-1:3]);
  assign req_s      = memRead | memWrite;
  assign misalign_s = (memMode == 1'b0) && (lane_s != 2'b00);
  // Old contents: gives read-before-write when load and store coincide.
  assign rd_word_s  = mem_r[word_idx_s];

`ifdef DMEM_MMIO_EN
  logic [WORD_WIDTH-1:0] cycle_r;
  logic [WORD_WIDTH-1:0] tohost_data_r;
  logic                  tohost_valid_r;
  logic                  tohost_we_s;
`endif

  // Byte lane extraction for loads and lane merge for byte stores.
  always_comb begin
    lane_byte_s = 8'h00;
    merged_s    = rd_word_s;
    case (lane_s)
      2'd0: begin lane_byte_s = rd_word_s[7:0];   merged_s[7:0]   = dataIn[7:0]; end
      2'd1: begin lane_byte_s = rd_word_s[15:8];  merged_s[15:8]  = dataIn[7:0]; end
      2'd2: begin lane_byte_s = rd_word_s[23:16]; merged_s[23:16] = dataIn[7:0]; end
      2'd3: begin lane_byte_s = rd_word_s[31:24]; merged_s[31:24] = dataIn[7:0]; end
      default: begin lane_byte_s = 8'h00; merged_s = rd_word_s; end
    endcase
  end

  // Request decode: read data, storage write enable and write data.
  always_comb begin
    rd_data_s   = '0;
    mem_we_s    = 1'b0;
    mem_wdata_s = rd_word_s;
`ifdef DMEM_MMIO_EN
    tohost_we_s = 1'b0;
`endif
    if (memMode == 1'b1) begin
      if (in_range_s) begin
        rd_data_s   = {{(WORD_WIDTH-8){1'b0}}, lane_byte_s};
        mem_we_s    = memWrite;
        mem_wdata_s = merged_s;
      end else begin
        // Byte accesses outside storage (including the MMIO window) are void.
        rd_data_s = '0;
      end
    end else if (misalign_s) begin
      rd_data_s = '0;
    end else if (in_range_s) begin
      rd_data_s   = rd_word_s;
      mem_we_s    = memWrite;
      mem_wdata_s = dataIn;
    end else if (window_s) begin
`ifdef DMEM_MMIO_EN
      if (addr[2] == 1'b0) begin
        rd_data_s   = tohost_data_r;
        tohost_we_s = memWrite;
      end else begin
        rd_data_s = cycle_r;
      end
`else
      rd_data_s = '0;
`endif
    end else begin
      rd_data_s = '0;
    end
  end

  // Storage write port; contents survive reset, requests during reset drop.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) begin
      mem_r[word_idx_s] <= mem_wdata_s;
    end
  end

  // Registered load data and the sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dataOut    <= '0;
      misaligned <= 1'b0;
    end else begin
      if (memRead) begin
        dataOut <= rd_data_s;
      end
      if (req_s && misalign_s) begin
        misaligned <= 1'b1;
      end
    end
  end

`ifdef DMEM_MMIO_EN
  // MMIO state: cycle counter, tohost latch and its one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_r        <= '0;
      tohost_data_r  <= '0;
      tohost_valid_r <= 1'b0;
    end else begin
      cycle_r        <= cycle_r + WORD_WIDTH'(32'd1);
      tohost_valid_r <= tohost_we_s;
      if (tohost_we_s) begin
        tohost_data_r <= dataIn;
      end
    end
  end

  assign tohost_valid = tohost_valid_r;
  assign tohost_data  = tohost_data_r;
`else
  assign tohost_valid = 1'b0;
  assign tohost_data  = '0;
`endif

endmodule
